// File: rtl/scr1_ahb_mem_arb_if.sv
// Bus bundle for the two-master AHB-Lite memory arbiter: imem/dmem masters plus the shared memory slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface scr1_ahb_mem_arb_if #(
  parameter int SCR1_AHB_WIDTH = 32
);
  logic [1:0]                imem_htrans;
  logic [SCR1_AHB_WIDTH-1:0] imem_haddr;
  logic [2:0]                imem_hsize;
  logic                      imem_hready;
  logic [SCR1_AHB_WIDTH-1:0] imem_hrdata;
  logic                      imem_hresp;

  logic [1:0]                dmem_htrans;
  logic [SCR1_AHB_WIDTH-1:0] dmem_haddr;
  logic [2:0]                dmem_hsize;
  logic                      dmem_hwrite;
  logic [SCR1_AHB_WIDTH-1:0] dmem_hwdata;
  logic                      dmem_hready;
  logic [SCR1_AHB_WIDTH-1:0] dmem_hrdata;
  logic                      dmem_hresp;

  logic [1:0]                mem_htrans;
  logic [SCR1_AHB_WIDTH-1:0] mem_haddr;
  logic [2:0]                mem_hsize;
  logic                      mem_hwrite;
  logic [SCR1_AHB_WIDTH-1:0] mem_hwdata;
  logic                      mem_hready;
  logic [SCR1_AHB_WIDTH-1:0] mem_hrdata;
  logic                      mem_hresp;

  modport slave (
    input  imem_htrans, imem_haddr, imem_hsize,
    output imem_hready, imem_hrdata, imem_hresp,
    input  dmem_htrans, dmem_haddr, dmem_hsize, dmem_hwrite, dmem_hwdata,
    output dmem_hready, dmem_hrdata, dmem_hresp,
    output mem_htrans, mem_haddr, mem_hsize, mem_hwrite, mem_hwdata,
    input  mem_hready, mem_hrdata, mem_hresp
  );

  modport master (
    output imem_htrans, imem_haddr, imem_hsize,
    input  imem_hready, imem_hrdata, imem_hresp,
    output dmem_htrans, dmem_haddr, dmem_hsize, dmem_hwrite, dmem_hwdata,
    input  dmem_hready, dmem_hrdata, dmem_hresp,
    input  mem_htrans, mem_haddr, mem_hsize, mem_hwrite, mem_hwdata,
    output mem_hready, mem_hrdata, mem_hresp
  );
endinterface

// File: rtl/scr1_ahb_mem_arb.sv
// Two-master AHB-Lite arbiter onto one memory slave; SCR1_AHB_ARB_RR_EN selects round-robin, else dmem has fixed priority.
// Zero-cycle grant in an open slot; losers see hready=0, and a completed response whose owner lost is held until its next grant.
module scr1_ahb_mem_arb #(
  parameter int SCR1_AHB_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  scr1_ahb_mem_arb_if.slave  bus
);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {OWN_NONE, OWN_IMEM, OWN_DMEM} owner_e;

  owner_e                    data_owner;
  owner_e                    data_owner_nxt;
  logic                      imem_req;
  logic                      dmem_req;
  logic                      slot_open;
  logic                      grant_imem;
  logic                      grant_dmem;
  logic                      imem_capture;
  logic                      dmem_capture;
  logic                      imem_hold_clr;
  logic                      dmem_hold_clr;
  logic                      imem_hold_vld;
  logic                      dmem_hold_vld;
  logic [SCR1_AHB_WIDTH-1:0] imem_hold_dat;
  logic [SCR1_AHB_WIDTH-1:0] dmem_hold_dat;
  logic                      imem_hold_resp;
  logic                      dmem_hold_resp;
`ifdef SCR1_AHB_ARB_RR_EN
  owner_e                    last_grant;
`endif

  assign imem_req  = (bus.imem_htrans == HTRANS_NONSEQ);
  assign dmem_req  = (bus.dmem_htrans == HTRANS_NONSEQ);
  assign slot_open = (data_owner == OWN_NONE) || bus.mem_hready;

  always_comb begin
    grant_imem = 1'b0;
    grant_dmem = 1'b0;
    if (!rst && slot_open) begin
`ifdef SCR1_AHB_ARB_RR_EN
      if (imem_req && dmem_req) begin
        grant_dmem = (last_grant == OWN_IMEM);
        grant_imem = (last_grant != OWN_IMEM);
      end else begin
        grant_imem = imem_req;
        grant_dmem = dmem_req;
      end
`else
      grant_dmem = dmem_req;
      grant_imem = imem_req && !dmem_req;
`endif
    end
  end

  always_comb begin
    data_owner_nxt = data_owner;
    if (slot_open) begin
      if (grant_dmem)      data_owner_nxt = OWN_DMEM;
      else if (grant_imem) data_owner_nxt = OWN_IMEM;
      else                 data_owner_nxt = OWN_NONE;
    end
  end

  // An open slot with a live owner means its data phase just completed.
  assign imem_capture  = slot_open && (data_owner == OWN_IMEM) && imem_req && !grant_imem;
  assign dmem_capture  = slot_open && (data_owner == OWN_DMEM) && dmem_req && !grant_dmem;
  assign imem_hold_clr = imem_hold_vld && (grant_imem || !imem_req);
  assign dmem_hold_clr = dmem_hold_vld && (grant_dmem || !dmem_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_owner    <= OWN_NONE;
      imem_hold_vld <= 1'b0;
      dmem_hold_vld <= 1'b0;
    end else begin
      data_owner <= data_owner_nxt;
      if (imem_capture)       imem_hold_vld <= 1'b1;
      else if (imem_hold_clr) imem_hold_vld <= 1'b0;
      if (dmem_capture)       dmem_hold_vld <= 1'b1;
      else if (dmem_hold_clr) dmem_hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_capture) begin
      imem_hold_dat  <= bus.mem_hrdata;
      imem_hold_resp <= bus.mem_hresp;
    end
    if (dmem_capture) begin
      dmem_hold_dat  <= bus.mem_hrdata;
      dmem_hold_resp <= bus.mem_hresp;
    end
  end

`ifdef SCR1_AHB_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_IMEM;
    end else if (grant_dmem) begin
      last_grant <= OWN_DMEM;
    end else if (grant_imem) begin
      last_grant <= OWN_IMEM;
    end
  end
`endif

  always_comb begin
    bus.mem_htrans = HTRANS_IDLE;
    bus.mem_haddr  = '0;
    bus.mem_hsize  = '0;
    bus.mem_hwrite = 1'b0;
    if (grant_dmem) begin
      bus.mem_htrans = HTRANS_NONSEQ;
      bus.mem_haddr  = bus.dmem_haddr;
      bus.mem_hsize  = bus.dmem_hsize;
      bus.mem_hwrite = bus.dmem_hwrite;
    end else if (grant_imem) begin
      bus.mem_htrans = HTRANS_NONSEQ;
      bus.mem_haddr  = bus.imem_haddr;
      bus.mem_hsize  = bus.imem_hsize;
    end
  end

  assign bus.mem_hwdata = (data_owner == OWN_DMEM) ? bus.dmem_hwdata : '0;

  // A requester only completes when granted; an idle non-owner is always ready.
  always_comb begin
    bus.imem_hready = 1'b1;
    bus.imem_hrdata = '0;
    bus.imem_hresp  = 1'b0;
    bus.dmem_hready = 1'b1;
    bus.dmem_hrdata = '0;
    bus.dmem_hresp  = 1'b0;
    if (!rst) begin
      if (imem_req)                    bus.imem_hready = grant_imem;
      else if (data_owner == OWN_IMEM) bus.imem_hready = bus.mem_hready;
      if (dmem_req)                    bus.dmem_hready = grant_dmem;
      else if (data_owner == OWN_DMEM) bus.dmem_hready = bus.mem_hready;

      if (data_owner == OWN_IMEM) begin
        bus.imem_hrdata = bus.mem_hrdata;
        bus.imem_hresp  = bus.mem_hresp;
      end else if (imem_hold_vld) begin
        bus.imem_hrdata = imem_hold_dat;
        bus.imem_hresp  = imem_hold_resp;
      end
      if (data_owner == OWN_DMEM) begin
        bus.dmem_hrdata = bus.mem_hrdata;
        bus.dmem_hresp  = bus.mem_hresp;
      end else if (dmem_hold_vld) begin
        bus.dmem_hrdata = dmem_hold_dat;
        bus.dmem_hresp  = dmem_hold_resp;
      end
    end
  end
endmodule

// File: tb/tb_scr1_ahb_mem_arb.sv
// Directed bench for scr1_ahb_mem_arb: a transaction-level model checked every cycle plus literal scenario expectations.
module tb_scr1_ahb_mem_arb;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  scr1_ahb_mem_arb_if #(.SCR1_AHB_WIDTH(32)) bus();

  scr1_ahb_mem_arb #(.SCR1_AHB_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Model state: who owns the pending data phase (0 none, 1 imem, 2 dmem) and per-master held responses.
  int          m_owner = 0;
  bit          m_hv [2];
  logic [31:0] m_hd [2];
  bit          m_hr [2];
  int          m_last = 0;

  function automatic bit req(input int m);
    return (m == 0) ? (bus.imem_htrans == NS) : (bus.dmem_htrans == NS);
  endfunction

  // Which master gets the address slot this cycle, -1 for none.
  function automatic int winner();
    if (rst || !((m_owner == 0) || bus.mem_hready)) return -1;
    if (req(0) && req(1)) begin
`ifdef SCR1_AHB_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    if (req(1)) return 1;
    if (req(0)) return 0;
    return -1;
  endfunction

  function automatic logic exp_rdy(input int m, input int w);
    if (rst) return 1'b1;
    if (req(m)) return (w == m);
    return (m_owner == m + 1) ? bus.mem_hready : 1'b1;
  endfunction

  function automatic logic [31:0] exp_dat(input int m);
    if (rst) return 32'h0;
    if (m_owner == m + 1) return bus.mem_hrdata;
    return m_hv[m] ? m_hd[m] : 32'h0;
  endfunction

  function automatic logic exp_resp(input int m);
    if (rst) return 1'b0;
    if (m_owner == m + 1) return bus.mem_hresp;
    return m_hv[m] ? m_hr[m] : 1'b0;
  endfunction

  always @(posedge clk) begin
    int w;
    w = winner();
    if (rst) begin
      m_owner = 0;
      m_last  = 0;
      m_hv[0] = 1'b0;
      m_hv[1] = 1'b0;
    end else begin
      for (int m = 0; m < 2; m++)
        if (m_hv[m] && ((w == m) || !req(m))) m_hv[m] = 1'b0;
      if (m_owner != 0 && bus.mem_hready && req(m_owner - 1) && (w != m_owner - 1)) begin
        m_hv[m_owner-1] = 1'b1;
        m_hd[m_owner-1] = bus.mem_hrdata;
        m_hr[m_owner-1] = bus.mem_hresp;
      end
      if ((m_owner == 0) || bus.mem_hready) m_owner = w + 1;
      if (w >= 0) m_last = w;
    end
  end

  always @(negedge clk) begin
    int w;
    w = winner();
    chk("mem_htrans", {30'h0, bus.mem_htrans}, (w < 0) ? 32'h0 : 32'h2);
    chk("mem_haddr", bus.mem_haddr, (w == 1) ? bus.dmem_haddr : (w == 0) ? bus.imem_haddr : 32'h0);
    chk("mem_hsize", {29'h0, bus.mem_hsize},
        {29'h0, (w == 1) ? bus.dmem_hsize : (w == 0) ? bus.imem_hsize : 3'b000});
    chk("mem_hwrite", {31'h0, bus.mem_hwrite}, {31'h0, (w == 1) ? bus.dmem_hwrite : 1'b0});
    chk("mem_hwdata", bus.mem_hwdata, (m_owner == 2) ? bus.dmem_hwdata : 32'h0);
    chk("imem_hready", {31'h0, bus.imem_hready}, {31'h0, exp_rdy(0, w)});
    chk("dmem_hready", {31'h0, bus.dmem_hready}, {31'h0, exp_rdy(1, w)});
    chk("imem_hrdata", bus.imem_hrdata, exp_dat(0));
    chk("dmem_hrdata", bus.dmem_hrdata, exp_dat(1));
    chk("imem_hresp", {31'h0, bus.imem_hresp}, {31'h0, exp_resp(0)});
    chk("dmem_hresp", {31'h0, bus.dmem_hresp}, {31'h0, exp_resp(1)});
  end

  task automatic drive(input logic r, input logic [1:0] it, input logic [31:0] ia,
                       input logic [1:0] dt, input logic [31:0] da, input logic dw,
                       input logic [31:0] dwd, input logic mr, input logic [31:0] md,
                       input logic mresp);
    @(posedge clk);
    #1;
    rst             = r;
    bus.imem_htrans = it;
    bus.imem_haddr  = ia;
    bus.dmem_htrans = dt;
    bus.dmem_haddr  = da;
    bus.dmem_hwrite = dw;
    bus.dmem_hwdata = dwd;
    bus.mem_hready  = mr;
    bus.mem_hrdata  = md;
    bus.mem_hresp   = mresp;
    #3;
  endtask

  task automatic idle(input logic r);
    drive(r, ID, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
  endtask

  initial begin
    logic [3:0]  slot_exp [4];
    logic [31:0] ia;
    logic [31:0] da;
    bus.imem_hsize  = 3'b010;
    bus.dmem_hsize  = 3'b001;
    bus.imem_htrans = ID;
    bus.imem_haddr  = 32'h0;
    bus.dmem_htrans = ID;
    bus.dmem_haddr  = 32'h0;
    bus.dmem_hwrite = 1'b0;
    bus.dmem_hwdata = 32'h0;
    bus.mem_hready  = 1'b1;
    bus.mem_hrdata  = 32'h0;
    bus.mem_hresp   = 1'b0;

    // Reset with a request pending: nothing may reach the slave.
    drive(1'b1, NS, 32'h40, NS, 32'h44, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    chk("rst_htrans", {30'h0, bus.mem_htrans}, 32'h0);
    chk("rst_imem_hready", {31'h0, bus.imem_hready}, 32'h1);
    chk("rst_dmem_hready", {31'h0, bus.dmem_hready}, 32'h1);
    idle(1'b1);

    // Lone imem fetch, zero-wait slave.
    drive(1'b0, NS, 32'h100, ID, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    chk("s1_haddr", bus.mem_haddr, 32'h100);
    chk("s1_htrans", {30'h0, bus.mem_htrans}, 32'h2);
    chk("s1_imem_hready_a", {31'h0, bus.imem_hready}, 32'h1);
    drive(1'b0, ID, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0);
    chk("s1_imem_hready_d", {31'h0, bus.imem_hready}, 32'h1);
    chk("s1_imem_hrdata", bus.imem_hrdata, 32'h13);

    // Simultaneous requests: dmem write first, imem waits one cycle.
    drive(1'b0, NS, 32'h200, NS, 32'h1000, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
    chk("s2_haddr_d", bus.mem_haddr, 32'h1000);
    chk("s2_hwrite", {31'h0, bus.mem_hwrite}, 32'h1);
    chk("s2_imem_wait", {31'h0, bus.imem_hready}, 32'h0);
    drive(1'b0, NS, 32'h200, ID, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    chk("s2_hwdata", bus.mem_hwdata, 32'hDEADBEEF);
    chk("s2_haddr_i", bus.mem_haddr, 32'h200);
    chk("s2_imem_go", {31'h0, bus.imem_hready}, 32'h1);
    drive(1'b0, ID, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b1, 32'h77, 1'b0);
    chk("s2_imem_hrdata", bus.imem_hrdata, 32'h77);

    // imem data phase with two wait states, then loses the next slot: response held.
    drive(1'b0, NS, 32'h300, ID, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    chk("s3_haddr_a", bus.mem_haddr, 32'h300);
    drive(1'b0, NS, 32'h304, ID, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("s3_wait1", {31'h0, bus.imem_hready}, 32'h0);
    drive(1'b0, NS, 32'h304, ID, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("s3_wait2", {31'h0, bus.imem_hready}, 32'h0);
    drive(1'b0, NS, 32'h304, NS, 32'h2000, 1'b0, 32'h0, 1'b1, 32'h55, 1'b0);
    chk("s3_haddr_d", bus.mem_haddr, 32'h2000);
    chk("s3_imem_held", {31'h0, bus.imem_hready}, 32'h0);
    drive(1'b0, NS, 32'h304, ID, 32'h0, 1'b0, 32'h0, 1'b1, 32'h99, 1'b0);
    chk("s3_imem_release", {31'h0, bus.imem_hready}, 32'h1);
    chk("s3_imem_hold_dat", bus.imem_hrdata, 32'h55);
    chk("s3_haddr_i", bus.mem_haddr, 32'h304);
    chk("s3_dmem_hrdata", bus.dmem_hrdata, 32'h99);
    drive(1'b0, ID, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b1, 32'h66, 1'b0);
    chk("s3_imem_next", bus.imem_hrdata, 32'h66);

    // Two-cycle ERROR response on a dmem read.
    drive(1'b0, ID, 32'h0, NS, 32'h3000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    drive(1'b0, ID, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("s4_err1_resp", {31'h0, bus.dmem_hresp}, 32'h1);
    chk("s4_err1_rdy", {31'h0, bus.dmem_hready}, 32'h0);
    chk("s4_err1_imem", {31'h0, bus.imem_hresp}, 32'h0);
    drive(1'b0, ID, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    chk("s4_err2_resp", {31'h0, bus.dmem_hresp}, 32'h1);
    chk("s4_err2_rdy", {31'h0, bus.dmem_hready}, 32'h1);
    chk("s4_err2_imem", {31'h0, bus.imem_hresp}, 32'h0);
    idle(1'b0);

    // Continuous contention from reset: slot owner shown by address nibble (5 = imem, 6 = dmem).
`ifdef SCR1_AHB_ARB_RR_EN
    slot_exp[0] = 4'h6; slot_exp[1] = 4'h5; slot_exp[2] = 4'h6; slot_exp[3] = 4'h5;
`else
    slot_exp[0] = 4'h6; slot_exp[1] = 4'h6; slot_exp[2] = 4'h6; slot_exp[3] = 4'h6;
`endif
    idle(1'b1);
    ia = 32'h5000;
    da = 32'h6000;
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, NS, ia, NS, da, 1'b0, 32'h0, 1'b1, 32'h100 + s, 1'b0);
      chk("s5_slot_owner", {28'h0, bus.mem_haddr[15:12]}, {28'h0, slot_exp[s]});
      if (bus.imem_hready) ia = ia + 32'h4;
      if (bus.dmem_hready) da = da + 32'h4;
    end
    idle(1'b0);
    idle(1'b0);

    // Reset in the middle of a waited dmem write.
    drive(1'b0, ID, 32'h0, NS, 32'h7000, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
    drive(1'b1, ID, 32'h0, ID, 32'h0, 1'b0, 32'h1234, 1'b0, 32'h0, 1'b0);
    chk("s6_rst_htrans", {30'h0, bus.mem_htrans}, 32'h0);
    drive(1'b0, ID, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b0, 32'hAA, 1'b1);
    chk("s6_htrans", {30'h0, bus.mem_htrans}, 32'h0);
    chk("s6_imem_hready", {31'h0, bus.imem_hready}, 32'h1);
    chk("s6_dmem_hready", {31'h0, bus.dmem_hready}, 32'h1);
    chk("s6_dmem_hrdata", bus.dmem_hrdata, 32'h0);
    chk("s6_dmem_hresp", {31'h0, bus.dmem_hresp}, 32'h0);
    drive(1'b0, NS, 32'h800, ID, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    chk("s6_haddr_after", bus.mem_haddr, 32'h800);
    idle(1'b0);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
